// File: rtl/fact_pkg.sv
// Shared constants and state encoding for the fact_top host sequencer.
package fact_pkg;

    localparam logic [1:0] FACT_A_N    = 2'd0;
    localparam logic [1:0] FACT_A_GO   = 2'd1;
    localparam logic [1:0] FACT_A_STAT = 2'd2;
    localparam logic [1:0] FACT_A_RES  = 2'd3;

    localparam int FACT_DONE_BIT = 0;
    localparam int FACT_ERR_BIT  = 1;

    typedef enum logic [2:0] {
        IDLE,
        WR_N,
        WR_GO,
        CLR_GO,
        POLL,
        RD_RES,
        RESP
    } fact_state_t;

endpackage

// File: rtl/fact_poll_timer.sv
// Saturating poll counter; expired marks the last permitted poll cycle.
module fact_poll_timer #(
    parameter int TIMEOUT = 1024,
    parameter int TW      = 11
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] count;

    // Holds at LAST instead of wrapping so a stuck POLL can never re-arm.
    always_ff @(posedge clk) begin
        if (rst || clr)
            count <= '0;
        else if (en && count != LAST)
            count <= count + 1'b1;
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/fact_host_sequencer.sv
// Runs one factorial job on fact_top: write n, pulse go, poll status, read result, respond.
module fact_host_sequencer
    import fact_pkg::*;
#(
    parameter int TIMEOUT = 1024,
    parameter int TW      = 11
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_n,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic [1:0]  fa_A,
    output logic        fa_WE,
    output logic [3:0]  fa_WD,
    input  logic [31:0] fa_RD
);

    fact_state_t state, state_n;
    logic [3:0]  n_q, n_n;
    logic [31:0] result_n;
    logic        err_n, to_n, valid_n;
    logic [1:0]  a_n;
    logic        we_n;
    logic [3:0]  wd_n;
    logic        expired;

    fact_poll_timer #(.TIMEOUT(TIMEOUT), .TW(TW)) u_timer (
        .clk     (Clk),
        .rst     (Rst),
        .clr     (state == CLR_GO),
        .en      (state == POLL),
        .expired (expired)
    );

    assign req_ready = (state == IDLE);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state       <= IDLE;
            n_q         <= '0;
            rsp_valid   <= 1'b0;
            rsp_result  <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            fa_A        <= FACT_A_N;
            fa_WE       <= 1'b0;
            fa_WD       <= '0;
        end else begin
            state       <= state_n;
            n_q         <= n_n;
            rsp_valid   <= valid_n;
            rsp_result  <= result_n;
            rsp_err     <= err_n;
            rsp_timeout <= to_n;
            fa_A        <= a_n;
            fa_WE       <= we_n;
            fa_WD       <= wd_n;
        end
    end

    always_comb begin
        state_n  = state;
        n_n      = n_q;
        result_n = rsp_result;
        err_n    = rsp_err;
        to_n     = rsp_timeout;
        case (state)
            IDLE: if (req_valid) begin
                n_n      = req_n;
                result_n = '0;
                err_n    = 1'b0;
                to_n     = 1'b0;
                state_n  = WR_N;
            end
            WR_N:   state_n = WR_GO;
            WR_GO:  state_n = CLR_GO;
            CLR_GO: state_n = POLL;
            POLL: begin
                // err outranks done: a faulted job never exposes its result register
                if (fa_RD[FACT_ERR_BIT]) begin
                    err_n   = 1'b1;
                    state_n = RESP;
                end else if (fa_RD[FACT_DONE_BIT]) begin
                    state_n = RD_RES;
                end else if (expired) begin
                    to_n    = 1'b1;
                    state_n = RESP;
                end
            end
            RD_RES: begin
                result_n = fa_RD;
                state_n  = RESP;
            end
            RESP:    if (rsp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // Bus outputs are registered, so they are decoded from the state being entered.
        a_n     = FACT_A_N;
        we_n    = 1'b0;
        wd_n    = '0;
        valid_n = (state_n == RESP);
        case (state_n)
            WR_N: begin
                we_n = 1'b1;
                wd_n = n_n;
            end
            WR_GO: begin
                a_n  = FACT_A_GO;
                we_n = 1'b1;
                wd_n = 4'h1;
            end
            CLR_GO: begin
                a_n  = FACT_A_GO;
                we_n = 1'b1;
            end
            POLL:    a_n = FACT_A_STAT;
            RD_RES:  a_n = FACT_A_RES;
            default: ;
        endcase
    end

endmodule

// File: doc/fact_host_sequencer.md
Name: fact_host_sequencer

Overview:
- Upstream command master for the fact_top factorial accelerator. It accepts one factorial request on a valid/ready channel, drives the accelerator's 2-bit-address register port, and polls status until done or error. It then reads the result and returns it on a valid/ready response channel.
- It sits between the SoC request source (CPU/bus glue) and fact_top, replacing software polling.

Parameters:
- TIMEOUT, 1024, max POLL cycles before abandoning a job (>=2)
- TW, 11, timeout counter width, must satisfy 2**TW > TIMEOUT

Ports:
- Clk  in  1  system clock, all state on rising edge
- Rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept request
- req_n  in  4  factorial operand n
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  32  n! (0 when rsp_err or rsp_timeout)
- rsp_err  out  1  accelerator flagged error (operand out of range)
- rsp_timeout  out  1  no done/err within TIMEOUT polls
- fa_A  out  2  accelerator register address
- fa_WE  out  1  accelerator write enable
- fa_WD  out  4  accelerator write data
- fa_RD  in  32  accelerator read data, combinational from fa_A

Behaviour:
- Clocking and reset: one clock Clk; reset Rst is synchronous and active-high.
- Accelerator map (fixed):
  - A=0: write n
  - A=1: go, WD[0]
  - A=2: status, RD[0]=done, RD[1]=err
  - A=3: result
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_result=0, rsp_err=0, rsp_timeout=0, fa_A=0, fa_WE=0, fa_WD=0, timer=0.
- Reset mid-job returns to IDLE next edge and drops rsp_valid. No partial response.
- fa_* outputs are registered. Each state below lasts exactly one cycle unless stated otherwise.
- FSM:
  - IDLE: req_ready=1. On req_valid&&req_ready, capture req_n and go to WR_N. req_ready is 0 in every other state.
  - WR_N: fa_A=0, fa_WE=1, fa_WD=n; go to WR_GO.
  - WR_GO: fa_A=1, fa_WE=1, fa_WD=4'h1; go to CLR_GO.
  - CLR_GO: fa_A=1, fa_WE=1, fa_WD=4'h0; clear timer; go to POLL.
  - POLL: fa_A=2, fa_WE=0; sample fa_RD each cycle, timer increments.
    - If fa_RD[1]=1, go to RESP with err=1. err has priority over done if both are set.
    - Else if fa_RD[0]=1, go to RD_RES.
    - Else if timer==TIMEOUT-1, go to RESP with timeout=1.
  - RD_RES: fa_A=3, fa_WE=0; rsp_result<=fa_RD; go to RESP.
  - RESP: rsp_valid=1. Outputs hold stable until rsp_ready. On rsp_valid&&rsp_ready, clear rsp_valid and return to IDLE.
- Latency: request handshake to rsp_valid is 5+P cycles, where P is the number of POLL cycles (>=1). The error path is one cycle shorter, since RD_RES is skipped.
- Single outstanding job; no request queuing.
- A req_valid asserted while busy is ignored until IDLE. Same-cycle rsp handshake and new req_valid: the request is accepted on the following cycle (IDLE).
- fa_WE is 0 in IDLE, POLL, RD_RES and RESP.
- The timer saturates and never wraps.
- req_n is captured at the handshake; later changes to req_n are ignored.

Decomposition:
- Shared package fact_pkg:
  - address constants FACT_A_N=0, FACT_A_GO=1, FACT_A_STAT=2, FACT_A_RES=3
  - status bit indices FACT_DONE_BIT=0, FACT_ERR_BIT=1
  - state enum (IDLE, WR_N, WR_GO, CLR_GO, POLL, RD_RES, RESP)
- One sub-module, fact_poll_timer: clear/enable/saturating counter with an expired flag at TIMEOUT-1.

Test Plan:
- Normal job, fact_top attached: req_n=7 → rsp_result=5040 (0x13B0), err=0, timeout=0.
- Operand 0 and max operand: req_n=0 → rsp_result=1; req_n=12 → 479001600 (0x1C8CFC00).
- Error path: req_n=13 → rsp_err=1, rsp_result=0, and no A=3 access is observed on fa_A.
- Timeout: stub fa_RD=0 and TIMEOUT=8 → rsp_timeout=1 exactly 8 POLL cycles after entering POLL.
- Backpressure: hold rsp_ready=0 for 10 cycles → rsp_valid and rsp_result stable, req_ready=0, a second req_valid is not accepted. Release → IDLE next cycle and the second request is accepted.
- Reset during POLL: Rst=1 for 1 cycle → next cycle all outputs at reset values. A new job with req_n=5 then returns 120.
